// File: rtl/otg_hpi_engine_if.sv
// HPI engine bus interface.
// Groups the command/response handshake and the CY7C67200 HPI pins.
//   master : command source (drives cmd_*, chip_rst_req, otg_hpi_data_in from the pad side)
//   slave  : the engine (drives cmd_ready, rsp_*, busy and all otg_hpi_* outputs)
interface otg_hpi_engine_if #(
    parameter int unsigned DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [1:0]        cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              chip_rst_req;
    logic              busy;
    logic              otg_hpi_cs_n;
    logic              otg_hpi_r_n;
    logic              otg_hpi_w_n;
    logic [1:0]        otg_hpi_addr;
    logic [DATA_W-1:0] otg_hpi_data_out;
    logic              otg_hpi_data_oe;
    logic [DATA_W-1:0] otg_hpi_data_in;
    logic              otg_hpi_reset_n;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, chip_rst_req, otg_hpi_data_in,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, otg_hpi_cs_n, otg_hpi_r_n,
               otg_hpi_w_n, otg_hpi_addr, otg_hpi_data_out, otg_hpi_data_oe, otg_hpi_reset_n
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, chip_rst_req, otg_hpi_data_in,
        output cmd_ready, rsp_valid, rsp_rdata, busy, otg_hpi_cs_n, otg_hpi_r_n,
               otg_hpi_w_n, otg_hpi_addr, otg_hpi_data_out, otg_hpi_data_oe, otg_hpi_reset_n
    );
endinterface

// File: rtl/otg_hpi_engine.sv
// HPI transaction engine for the CY7C67200 host port.
// Commands are queued in a small FIFO and executed by a sequencer producing
// setup/strobe/hold timing on cs_n/r_n/w_n; read data returns on a one-cycle pulse.
// Also sequences the chip reset pulse on otg_hpi_reset_n.
// Ports:
//   clk_clk     : system clock, rising edge
//   reset_reset : synchronous active-high reset
//   bus         : command/response handshake plus HPI pins (slave modport)
module otg_hpi_engine #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RESET_CYC  = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    otg_hpi_engine_if.slave      bus
);
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max2(max2(SETUP_CYC, STROBE_CYC),
                                           max2(HOLD_CYC, RESET_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned EW      = DATA_W + 3;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RESET_LD  = CNT_W'(RESET_CYC - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StReset} state_e;

    // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          empty, full, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.cmd_valid && !full;

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Sequencer state and the command currently on the bus.
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_clr, load, capture;
    logic              cur_write_q;
    logic [1:0]        cur_addr_q;
    logic [DATA_W-1:0] cur_wdata_q, rdata_q;
    logic [EW-1:0]     head;

    assign head = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            cur_write_q <= 1'b0;
            cur_addr_q  <= '0;
            cur_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // A request arriving on the very cycle of entry stays pending.
            pend_q  <= (pend_q && !pend_clr) || bus.chip_rst_req;
            if (load) begin
                cur_write_q <= head[EW-1];
                cur_addr_q  <= head[EW-2:EW-3];
                cur_wdata_q <= head[DATA_W-1:0];
            end
            if (capture) rdata_q <= bus.otg_hpi_data_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        load     = 1'b0;
        pend_clr = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    state_d  = StReset;
                    cnt_d    = RESET_LD;
                    pend_clr = 1'b1;
                end else if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = StSetup;
                    cnt_d   = SETUP_LD;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StStrobe;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    capture = !cur_write_q;
                    state_d = StHold;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold, StReset: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // HPI pins decode straight from registered state, so they are glitch-free per phase.
    logic active;
    assign active = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);

    assign bus.otg_hpi_cs_n     = !active;
    assign bus.otg_hpi_r_n      = !((state_q == StStrobe) && !cur_write_q);
    assign bus.otg_hpi_w_n      = !((state_q == StStrobe) && cur_write_q);
    assign bus.otg_hpi_addr     = active ? cur_addr_q : 2'b00;
    assign bus.otg_hpi_data_oe  = active && cur_write_q;
    assign bus.otg_hpi_data_out = (active && cur_write_q) ? cur_wdata_q : '0;
    assign bus.otg_hpi_reset_n  = (state_q != StReset);
    // Only the first HOLD cycle has the counter at its load value.
    assign bus.rsp_valid        = (state_q == StHold) && (cnt_q == HOLD_LD) && !cur_write_q;
    assign bus.rsp_rdata        = rdata_q;
    assign bus.cmd_ready        = !full;
    assign bus.busy             = (state_q != StIdle) || !empty || pend_q;
endmodule

// File: tb/tb_otg_hpi_engine.sv
// Directed bench for otg_hpi_engine with default parameters.
// Cycle k of a step is the interval after the k-th rising edge counted from the
// cycle in which the first command of that step is offered (k = 0).
module tb_otg_hpi_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    otg_hpi_engine_if #(.DATA_W(16)) bus ();

    otg_hpi_engine #(
        .DATA_W(16), .FIFO_DEPTH(4), .SETUP_CYC(1), .STROBE_CYC(4), .HOLD_CYC(1), .RESET_CYC(16)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Passive monitor: data of every write strobe, and cs_n-high run length before each access.
    logic [15:0] wr_log [$];
    int          gap_log [$];
    logic        prev_w_n  = 1'b1;
    logic        prev_cs_n = 1'b1;
    logic        seen_low  = 1'b0;
    int          hi_run    = 0;

    always @(negedge clk) begin
        if (prev_w_n && !bus.otg_hpi_w_n) wr_log.push_back(bus.otg_hpi_data_out);
        if (!bus.otg_hpi_cs_n && prev_cs_n && seen_low) gap_log.push_back(hi_run);
        if (!bus.otg_hpi_cs_n) seen_low <= 1'b1;
        hi_run    <= bus.otg_hpi_cs_n ? hi_run + 1 : 0;
        prev_w_n  <= bus.otg_hpi_w_n;
        prev_cs_n <= bus.otg_hpi_cs_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({tag, "_busy"},      bus.busy, 0);
        chk({tag, "_cs_n"},      bus.otg_hpi_cs_n, 1);
        chk({tag, "_r_n"},       bus.otg_hpi_r_n, 1);
        chk({tag, "_w_n"},       bus.otg_hpi_w_n, 1);
        chk({tag, "_addr"},      bus.otg_hpi_addr, 0);
        chk({tag, "_data_out"},  bus.otg_hpi_data_out, 0);
        chk({tag, "_data_oe"},   bus.otg_hpi_data_oe, 0);
        chk({tag, "_reset_n"},   bus.otg_hpi_reset_n, 1);
    endtask

    initial begin
        int base;
        int gbase;
        int n;
        int lows;

        bus.cmd_valid       = 1'b0;
        bus.cmd_write       = 1'b0;
        bus.cmd_addr        = 2'd0;
        bus.cmd_wdata       = 16'h0;
        bus.chip_rst_req    = 1'b0;
        bus.otg_hpi_data_in = 16'h0;

        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) tick();
        check_reset_vals("rst_held");
        rst = 1'b0;
        tick();
        check_reset_vals("rst_rel");

        // Single write: cs_n/oe low k=2..7, w_n low k=3..6.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 2'd2;
        bus.cmd_wdata = 16'h1234;
        tick();
        bus.cmd_valid = 1'b0;
        chk("wr_cs_n_k1", bus.otg_hpi_cs_n, 1);
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk($sformatf("wr_cs_n_k%0d", k), bus.otg_hpi_cs_n, (k >= 2 && k <= 7) ? 0 : 1);
            chk($sformatf("wr_w_n_k%0d", k), bus.otg_hpi_w_n, (k >= 3 && k <= 6) ? 0 : 1);
            chk($sformatf("wr_r_n_k%0d", k), bus.otg_hpi_r_n, 1);
            chk($sformatf("wr_oe_k%0d", k), bus.otg_hpi_data_oe, (k >= 2 && k <= 7) ? 1 : 0);
            chk($sformatf("wr_dout_k%0d", k), bus.otg_hpi_data_out,
                (k >= 2 && k <= 7) ? 32'h1234 : 32'h0);
            chk($sformatf("wr_addr_k%0d", k), bus.otg_hpi_addr, (k >= 2 && k <= 7) ? 2 : 0);
            chk($sformatf("wr_rsp_k%0d", k), bus.rsp_valid, 0);
        end

        // Single read: r_n low k=3..6, rsp_valid only at k=7, data held afterwards.
        bus.otg_hpi_data_in = 16'hBEEF;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 2'd0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.cmd_valid = 1'b0;
            chk($sformatf("rd_r_n_k%0d", k), bus.otg_hpi_r_n, (k >= 3 && k <= 6) ? 0 : 1);
            chk($sformatf("rd_w_n_k%0d", k), bus.otg_hpi_w_n, 1);
            chk($sformatf("rd_oe_k%0d", k), bus.otg_hpi_data_oe, 0);
            chk($sformatf("rd_rsp_k%0d", k), bus.rsp_valid, (k == 7) ? 1 : 0);
        end
        chk("rd_rdata_k8", bus.rsp_rdata, 32'hBEEF);
        bus.otg_hpi_data_in = 16'h0000;
        repeat (3) tick();
        chk("rd_rdata_held", bus.rsp_rdata, 32'hBEEF);

        // Six back-to-back writes: FIFO fills after the fifth push, sixth waits for a pop.
        base  = wr_log.size();
        gbase = gap_log.size();
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 2'd1;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_wdata = 16'hA000 + 16'(i);
            tick();
        end
        chk("fifo_full_ready", bus.cmd_ready, 0);
        bus.cmd_wdata = 16'hA005;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("fifo_ready_wait", n, 4);
        tick();
        bus.cmd_valid = 1'b0;
        wait_idle(200);
        tick();
        chk("burst_count", wr_log.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < wr_log.size())
                chk($sformatf("burst_data%0d", i), wr_log[base + i], 32'hA000 + i);
        end
        chk("burst_gap_count", gap_log.size() - gbase, 6);
        for (int i = 1; i < 6; i++) begin
            if (gbase + i < gap_log.size())
                chk($sformatf("burst_gap%0d", i), gap_log[gbase + i], 1);
        end

        // Chip reset requested during a read: read finishes, reset_n low k=9..24, resume k=26.
        base = wr_log.size();
        bus.otg_hpi_data_in = 16'h5A5A;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 2'd1;
        for (int k = 1; k <= 27; k++) begin
            tick();
            bus.cmd_valid    = (k == 1 || k == 2);
            bus.cmd_write    = 1'b1;
            bus.cmd_addr     = (k == 1) ? 2'd3 : 2'd0;
            bus.cmd_wdata    = (k == 1) ? 16'hC0DE : 16'hF00D;
            bus.chip_rst_req = (k == 4);
            chk($sformatf("cr_rsp_k%0d", k), bus.rsp_valid, (k == 7) ? 1 : 0);
            chk($sformatf("cr_reset_n_k%0d", k), bus.otg_hpi_reset_n,
                (k >= 9 && k <= 24) ? 0 : 1);
            chk($sformatf("cr_cs_n_k%0d", k), bus.otg_hpi_cs_n,
                ((k >= 2 && k <= 7) || k >= 26) ? 0 : 1);
            if (k == 8)  chk("cr_rdata", bus.rsp_rdata, 32'h5A5A);
            if (k == 15) chk("cr_busy_in_reset", bus.busy, 1);
        end
        bus.cmd_valid    = 1'b0;
        bus.chip_rst_req = 1'b0;
        wait_idle(100);
        tick();
        chk("cr_wr_count", wr_log.size() - base, 2);
        if (wr_log.size() >= base + 2) begin
            chk("cr_wr0", wr_log[base], 32'hC0DE);
            chk("cr_wr1", wr_log[base + 1], 32'hF00D);
        end

        // Block reset during write strobe with a second command queued.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 2'd1;
        bus.cmd_wdata = 16'h7777;
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.cmd_valid = (k == 1);
            bus.cmd_wdata = 16'h8888;
            rst = (k == 4);
            if (k == 3) chk("abort_w_n_active", bus.otg_hpi_w_n, 0);
        end
        chk("abort_w_n", bus.otg_hpi_w_n, 1);
        chk("abort_cs_n", bus.otg_hpi_cs_n, 1);
        chk("abort_oe", bus.otg_hpi_data_oe, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_rsp", bus.rsp_valid, 0);
        lows = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (!bus.otg_hpi_cs_n) lows++;
        end
        chk("abort_quiet", lows, 0);
        chk("abort_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
